pipe_skid_reg: RTL

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous squash input. It replaces fixed 32-bit enable/clear stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls propagate as back-pressure without a combinational ready path, and hazard flushes insert a programmable bubble value.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/dffe_sclr.sv | 36 +++
 rtl/pipe_skid_reg.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the pipeline skid-buffer stage.
//   pipe_state_e : occupancy-coded FSM state, so the encoding can drive
//                  the Occupancy port directly.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/dffe_sclr.sv
// dffe_sclr
//   WIDTH-bit enable flop with a synchronous active-high clear to CLR_VAL.
//   clear has priority over enable.
//   Ports:
//     clk  in   clock, rising edge
//     clr  in   synchronous clear, loads CLR_VAL
//     en   in   load enable for d
//     d    in   WIDTH  next value
//     q    out  WIDTH  registered value
module dffe_sclr #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = CLR_VAL;
    else if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Pipeline-stage register with valid/ready handshake and a two-entry skid
//   buffer. In_Ready is registered, so downstream stalls never form a
//   combinational path back upstream. Flush squashes every held entry.
//   Ports:
//     Clk        in   clock
//     Clr        in   synchronous active-high reset
//     In_D       in   WIDTH  upstream payload
//     In_Valid   in   upstream offers In_D
//     In_Ready   out  block can accept this cycle (registered)
//     Flush      in   synchronous squash of held entries
//     Out_Q      out  WIDTH  main-slot payload (registered)
//     Out_Valid  out  Out_Q is live (registered)
//     Out_Ready  in   downstream consumes this cycle
//     Occupancy  out  2  held entries, 0..2
//
//   state | meaning
//   EMPTY | no entries, M and S hold BUBBLE
//   HALF  | M live, S holds BUBBLE
//   FULL  | M and S live, S is the younger entry
module pipe_skid_reg import pipe_pkg::*; #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [WIDTH-1:0] In_D,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic             Flush,
  output logic [WIDTH-1:0] Out_Q,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [1:0]       Occupancy
);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic             accept, drain;
  logic             m_load, m_from_s, m_bubble;
  logic             s_load, s_bubble;
  logic [WIDTH-1:0] m_q, s_q, m_d;

  assign accept = In_Valid & in_ready_q;
  assign drain  = out_valid_q & Out_Ready;

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_from_s = 1'b0;
    m_bubble = 1'b0;
    s_load   = 1'b0;
    s_bubble = 1'b0;
    if (Flush) begin
      // Anything offered or drained this cycle is simply dropped with the rest.
      state_d  = EMPTY;
      m_bubble = 1'b1;
      s_bubble = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = HALF;
            m_load  = 1'b1;
          end
        end
        HALF: begin
          if (accept && drain) begin
            m_load = 1'b1;
          end else if (accept) begin
            state_d = FULL;
            s_load  = 1'b1;
          end else if (drain) begin
            state_d  = EMPTY;
            m_bubble = 1'b1;
          end
        end
        FULL: begin
          // In_Ready is low here, so only a drain can move the state.
          if (drain) begin
            state_d  = HALF;
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_bubble = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_bubble = 1'b1;
          s_bubble = 1'b1;
        end
      endcase
    end
    m_d         = m_from_s ? s_q : In_D;
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  dffe_sclr #(.WIDTH(WIDTH), .CLR_VAL(BUBBLE)) u_main (
    .clk (Clk),
    .clr (Clr | m_bubble),
    .en  (m_load),
    .d   (m_d),
    .q   (m_q)
  );

  dffe_sclr #(.WIDTH(WIDTH), .CLR_VAL(BUBBLE)) u_skid (
    .clk (Clk),
    .clr (Clr | s_bubble),
    .en  (s_load),
    .d   (In_D),
    .q   (s_q)
  );

  assign Out_Q     = m_q;
  assign Out_Valid = out_valid_q;
  assign In_Ready  = in_ready_q;
  assign Occupancy = state_q;

endmodule
